// File: rtl/inst_encoder_pkg.sv
// ============================================================================
// Module      : inst_encoder_pkg
// Description : Shared RV32I format codes, opcodes and FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_encoder_pkg;

    // Immediate format select, shared with the immediate generator and decoder
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_R = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic        err;
        logic [31:0] inst;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // True when bits [31:LSB] of v are all copies of the sign bit
    function automatic logic sext_fits(input logic [31:0] v, input int lsb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= lsb && v[i] != v[31]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_encoder_enc_fifo2.sv
// ============================================================================
// Module      : enc_fifo2
// Description : Two-entry synchronous FIFO with full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign data_o  = mem_q[rd_ptr_q];

    // Pop is gated on non-empty, so a push into an empty FIFO never bypasses
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = ~wr_ptr_q;
        if (w_do_pop)  rd_ptr_d = ~rd_ptr_q;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_do_push) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
// ============================================================================
// Module      : inst_encoder
// Description : Streaming RV32I instruction encoder with range check and FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [2:0]           imm_src_i,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [31:0]          imm_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [31:0]          inst_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic [31:0]          w_inst;
    logic                 w_err;
    entry_t               w_entry;
    entry_t               w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Out-of-range immediates are still packed from their truncated bits
    always_comb begin
        w_inst = '0;
        w_err  = 1'b0;
        case (imm_src_i)
            IMM_I: begin
                w_inst = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                w_err  = !sext_fits(imm_i, 11);
            end
            IMM_S: begin
                w_inst = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                w_err  = !sext_fits(imm_i, 11);
            end
            IMM_B: begin
                w_inst = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
                w_err  = !sext_fits(imm_i, 12) || imm_i[0];
            end
            IMM_U: begin
                w_inst = {imm_i[31:12], rd_i, opcode_i};
                w_err  = |imm_i[11:0];
            end
            IMM_J: begin
                w_inst = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                w_err  = !sext_fits(imm_i, 20) || imm_i[0];
            end
            IMM_R: begin
                w_inst = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            default: begin
                w_inst = '0;
                w_err  = 1'b1;
            end
        endcase
    end

    assign w_entry = '{err: w_err, inst: w_inst};
    assign w_push  = valid_i && ready_o;
    assign w_pop   = valid_o && ready_i;

    enc_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_entry),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign ready_o = !w_full;
    assign valid_o = !w_empty;
    assign inst_o  = w_head.inst;
    assign err_o   = w_head.err;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (w_push && w_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt_o = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
// Module      : tb_inst_encoder
// Description : Self-checking bench for inst_encoder with a scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_encoder;

    localparam int CW     = 4;
    localparam int ERRMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [2:0]    imm_src_i;
    logic [6:0]    opcode_i;
    logic [2:0]    funct3_i;
    logic [6:0]    funct7_i;
    logic [4:0]    rd_i, rs1_i, rs2_i;
    logic [31:0]   imm_i;
    logic          valid_o;
    logic          ready_i;
    logic [31:0]   inst_o;
    logic          err_o;
    logic [CW-1:0] err_cnt_o;

    int checks   = 0;
    int failures = 0;
    int err_model = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [2:0]  src;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    inst_encoder #(.ERR_CNT_W(CW)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .imm_src_i (imm_src_i),
        .opcode_i  (opcode_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .rd_i      (rd_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .imm_i     (imm_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .inst_o    (inst_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    // Legality from the numeric range each format can represent
    function automatic bit legal(input logic [2:0] src, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        case (src)
            3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
            3'd2:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            3'd3:       return (imm % 4096) == 0;
            3'd4:       return (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && (s % 2 == 0);
            3'd5:       return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_inst(input logic [2:0] src, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [31:0] u);
        logic [31:0] base;
        base = 32'(op) | (32'(f3) << 12);
        case (src)
            3'd0: return ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | base;
            3'd1: return (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                         | ((u & 32'h1F) << 7) | base;
            3'd2: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                         | (32'(rs2) << 20) | (32'(rs1) << 15) | (((u >> 1) & 32'hF) << 8)
                         | (((u >> 11) & 32'h1) << 7) | base;
            3'd3: return (u & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            3'd4: return (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                         | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
                         | (32'(rd) << 7) | 32'(op);
            3'd5: return (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                         | (32'(rd) << 7) | base;
            default: return 32'h0;
        endcase
    endfunction

    // Immediate generator: recovers the immediate from an encoded word
    function automatic logic [31:0] immgen(input logic [31:0] w, input logic [2:0] src);
        case (src)
            3'd0:    return {{20{w[31]}}, w[31:20]};
            3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd3:    return {w[31:12], 12'h000};
            3'd4:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic set_req(input logic [2:0] src, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        imm_src_i = src; opcode_i = op; funct3_i = f3; funct7_i = f7;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
        set_req(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0; valid_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (inst_o !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        checks++; if (err_cnt_o !== '0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        err_model = 0;
    endtask

    task automatic test_encode();
        logic [2:0]  src [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0, 3'd2, 3'd6};
        logic [6:0]  op  [8] = '{7'h13, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h13, 7'h63, 7'h13};
        logic [2:0]  f3  [8] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5};
        logic [4:0]  rd  [8] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd5, 5'd1, 5'd0, 5'd9};
        logic [4:0]  rs1 [8] = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3};
        logic [4:0]  rs2 [8] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4};
        logic [31:0] imm [8] = '{32'd5, 32'd8, 32'hFFFFFFFC, 32'd2048, 32'h12345000,
                                 32'd2048, 32'd3, 32'd7};
        logic [31:0] exi [8] = '{32'h00500093, 32'h0020A423, 32'hFE000EE3, 32'h001000EF,
                                 32'h123452B7, 32'h80000093, 32'h00000163, 32'h00000000};
        logic        exe [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_req(src[k], op[k], f3[k], 7'h7F, rd[k], rs1[k], rs2[k], imm[k]);
            valid_i = 1'b1;
            checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL enc_pre_valid[%0d] got=%b exp=0", k, valid_o); end
            @(posedge clk);
            if (exe[k] && err_model < ERRMAX) err_model++;
            @(negedge clk);
            valid_i = 1'b0;
            checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL enc_valid[%0d] got=%b exp=1", k, valid_o); end
            checks++; if (inst_o !== exi[k]) begin failures++; $display("FAIL enc_inst[%0d] got=%h exp=%h", k, inst_o, exi[k]); end
            checks++; if (err_o !== exe[k]) begin failures++; $display("FAIL enc_err[%0d] got=%b exp=%b", k, err_o, exe[k]); end
            checks++; if (err_cnt_o !== CW'(err_model)) begin failures++; $display("FAIL enc_errcnt[%0d] got=%0d exp=%0d", k, err_cnt_o, err_model); end
            @(posedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ia, ib, ic;
        ia = model_inst(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd11);
        ib = model_inst(3'd0, 7'h13, 3'd0, 7'd0, 5'd3, 5'd4, 5'd0, 32'd22);
        ic = model_inst(3'd0, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'd33);
        @(negedge clk);
        ready_i = 1'b0; valid_i = 1'b1;
        set_req(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd11);
        @(posedge clk); @(negedge clk);
        set_req(3'd0, 7'h13, 3'd0, 7'd0, 5'd3, 5'd4, 5'd0, 32'd22);
        @(posedge clk); @(negedge clk);
        set_req(3'd0, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'd33);
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", ready_o); end
        @(posedge clk); @(negedge clk);
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_hold_ready got=%b exp=0", ready_o); end
        checks++; if (inst_o !== ia) begin failures++; $display("FAIL bp_head_a got=%h exp=%h", inst_o, ia); end
        ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (inst_o !== ib) begin failures++; $display("FAIL bp_head_b got=%h exp=%h", inst_o, ib); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop got=%b exp=1", ready_o); end
        @(posedge clk); @(negedge clk);
        valid_i = 1'b0;
        checks++; if (inst_o !== ic) begin failures++; $display("FAIL bp_head_c got=%h exp=%h", inst_o, ic); end
        checks++; if (valid_o !== 1'b1 || ready_o !== 1'b1) begin failures++; $display("FAIL bp_count1 got=%b%b exp=11", valid_o, ready_o); end
        @(posedge clk); @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", valid_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ready_i = 1'b0; valid_i = 1'b1;
        set_req(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL rst_mid_full got=%b exp=0", ready_o); end
        rst_i = 1'b1; ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_i = 1'b0; valid_i = 1'b0;
        err_model = 0;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", valid_o); end
        checks++; if (err_cnt_o !== '0) begin failures++; $display("FAIL rst_mid_errcnt got=%0d exp=0", err_cnt_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", ready_o); end
        @(posedge clk); @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_ignored got=%b exp=0", valid_o); end
    endtask

    task automatic test_random();
        exp_t        e;
        bit          push, pop;
        logic [2:0]  s;
        logic [31:0] im;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            checks++; if (valid_o !== (sb.size() > 0)) begin failures++; $display("FAIL rnd_valid c%0d got=%b", cyc, valid_o); end
            checks++; if (ready_o !== (sb.size() < 2)) begin failures++; $display("FAIL rnd_ready c%0d got=%b", cyc, ready_o); end
            checks++; if (err_cnt_o !== CW'(err_model)) begin failures++; $display("FAIL rnd_errcnt c%0d got=%0d exp=%0d", cyc, err_cnt_o, err_model); end
            if (sb.size() > 0) begin
                checks++; if (inst_o !== sb[0].inst || err_o !== sb[0].err) begin
                    failures++; $display("FAIL rnd_head c%0d got=%b/%h exp=%b/%h", cyc, err_o, inst_o, sb[0].err, sb[0].inst); end
                if (!sb[0].err && sb[0].src <= 3'd4) begin
                    checks++; if (immgen(inst_o, sb[0].src) !== sb[0].imm) begin
                        failures++; $display("FAIL rnd_roundtrip c%0d got=%h exp=%h", cyc, immgen(inst_o, sb[0].src), sb[0].imm); end
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                s  = 3'($urandom_range(0, 7));
                im = $urandom;
            end else begin
                s = 3'($urandom_range(0, 5));
                case (s)
                    3'd0, 3'd1: im = 32'($urandom_range(0, 4095)) - 32'd2048;
                    3'd2:       im = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
                    3'd3:       im = $urandom & 32'hFFFFF000;
                    3'd4:       im = (32'($urandom_range(0, (1 << 20) - 1)) - 32'(1 << 19)) << 1;
                    default:    im = $urandom;
                endcase
            end
            set_req(s, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), im);
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            push = valid_i && (sb.size() < 2);
            pop  = ready_i && (sb.size() > 0);
            e.src  = s;
            e.imm  = im;
            e.err  = !legal(s, im);
            e.inst = model_inst(s, opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, im);
            @(posedge clk);
            if (pop) void'(sb.pop_front());
            if (push) begin
                sb.push_back(e);
                if (e.err && err_model < ERRMAX) err_model++;
            end
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        sb.delete();
        @(negedge clk);
        set_req(3'd6, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF);
        valid_i = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (err_model < ERRMAX) err_model++;
            @(negedge clk);
            checks++; if (err_cnt_o !== CW'(err_model)) begin failures++; $display("FAIL sat_errcnt n%0d got=%0d exp=%0d", n, err_cnt_o, err_model); end
            checks++; if (inst_o !== 32'h0 || err_o !== 1'b1) begin failures++; $display("FAIL sat_word n%0d got=%b/%h exp=1/0", n, err_o, inst_o); end
        end
        valid_i = 1'b0;
        checks++; if (err_cnt_o !== CW'(ERRMAX)) begin failures++; $display("FAIL sat_final got=%0d exp=%0d", err_cnt_o, ERRMAX); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        set_req(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        test_reset();
        test_encode();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RV32I instruction encoder; the inverse of the immediate generator.
- Packs opcode, funct, register fields and a full 32-bit immediate into one 32-bit instruction word, scattering the immediate bits per format.
- Used by the boot/program loader and by self-checking benches to build instruction memory images.
- Valid/ready input, 2-entry output FIFO, range checking of the immediate, saturating error counter.

Parameters:
- ERR_CNT_W, 8, width of the saturating illegal-immediate counter.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  synchronous, active-high reset
- valid_i  input  1  request valid
- ready_o  output  1  encoder can accept a request
- imm_src_i  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R (no immediate); 110/111 illegal
- opcode_i  input  7  opcode field
- funct3_i  input  3  funct3 field
- funct7_i  input  7  funct7 field (R only)
- rd_i, rs1_i, rs2_i  input  5 each  register indices
- imm_i  input  32  signed byte-offset/immediate value
- valid_o  output  1  encoded word available
- ready_i  input  1  consumer accepts word
- inst_o  output  32  encoded instruction (head of FIFO)
- err_o  output  1  head word was produced from an out-of-range immediate or illegal imm_src
- err_cnt_o  output  ERR_CNT_W  saturating count of accepted erroneous requests

Behaviour:
- Reset: count=0, pointers=0, valid_o=0, inst_o=0, err_o=0, err_cnt_o=0, ready_o=1 in the cycle after reset deasserts.
- A reset mid-operation discards all buffered words. Any handshake in the reset cycle is ignored.
- Input push when valid_i && ready_o at a rising edge. Output pop when valid_o && ready_i.
- ready_o = (count < 2). It is a registered/count-derived signal with no combinational path from ready_i.
- Encoding is combinational on the inputs and written into the FIFO. Latency: a word accepted at edge N appears on inst_o/valid_o after edge N, i.e. one cycle.
- Field packing: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25]. Only the fields used by the selected format are driven; all others are 0.
- I: inst[31:20]=imm[11:0].
- S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
- B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
- U: inst[31:12]=imm[31:12].
- J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12].
- Range error, checked per format:
  - I/S: imm_i[31:11] is not all-equal.
  - B: imm_i[31:12] is not all-equal, or imm_i[0]=1.
  - J: imm_i[31:20] is not all-equal, or imm_i[0]=1.
  - U: imm_i[11:0] is not 0.
  - R: never errors.
- On a range error the word is still packed from the truncated bits and stored with err=1.
- Illegal imm_src: word = 0, err=1.
- err_cnt_o increments on each accepted erroneous push and saturates at all-ones.
- Simultaneous push and pop:
  - count=1: count stays 1, order is preserved.
  - count=0: push only; there is no bypass.
  - count=2: no push, because ready_o=0.
- Pointers are 1 bit and wrap 1→0.
- Round-trip invariant: for any non-error I/S/B/U/J word, feeding inst_o and the same imm_src into the immediate generator returns imm_i exactly.

Decomposition:
- Shared package holds:
  - the imm_src format codes (IMM_I..IMM_R), shared with the immediate generator and decoder;
  - the opcode constants;
  - the 33-bit {err, inst} entry width.
- One natural sub-module: enc_fifo2 (2-entry synchronous FIFO with count, full/empty).
- Packing and range checking stay in the top level.

Test Plan:
- addi x1,x0,5 (I, op 0010011, f3 000, rd 1, imm 5) → inst_o=0x00500093, err_o=0, valid_o one cycle after accept.
- sw x2,8(x1) (S, op 0100011, f3 010, rs1 1, rs2 2, imm 8) → 0x0020A423.
- beq x0,x0,-4 (B, op 1100011, imm 0xFFFFFFFC) → 0xFE000EE3. jal x1,2048 (J, op 1101111, rd 1) → 0x001000EF. lui x5,0x12345000 (U, op 0110111) → 0x123452B7.
- addi x1,x0,2048 → inst_o=0x80000093, err_o=1, err_cnt_o 0→1. B with imm 3 → err_o=1. imm_src 110 → inst_o=0, err_o=1.
- Back-pressure: hold ready_i=0 and push 3 requests → ready_o=0 after 2 accepted. Third is accepted only after the first pop. Output order is preserved. Simultaneous push/pop at count=1 keeps count=1.
- Fill FIFO with 2 words, assert rst_i for 1 cycle → valid_o=0, err_cnt_o=0, ready_o=1. Random legal stimulus round-trips through the immediate generator with no mismatch.
